regfile_op_sequencer: RTL
=========================

Name: regfile_op_sequencer

Overview:
Multicycle controller that sequences one register-register or register-immediate operation at a time through the 16x16 register file. It accepts a command over a valid/ready handshake and drives the register file's read and write controls. It captures operands, computes the result in a small internal ALU, then writes back and updates flags. It is the register file's only master in the datapath, so the file never sees a read/write conflict.

Parameters:
DATA_W, 16, register width; must match register file width
ADDR_W, 4, register index width (16 registers)
IMM_W, 8, immediate field width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  4  opcode
cmd_rdest  in  ADDR_W  destination / first-operand register
cmd_rsrc  in  ADDR_W  source register
cmd_imm  in  IMM_W  immediate
rf_rdest_loc  out  ADDR_W  to register file RdestRegLoc
rf_rsrc_loc  out  ADDR_W  to register file RsrcRegLoc
rf_en  out  1  register file write enable
rf_load  out  DATA_W  register file write data
rf_rdest_data  in  DATA_W  register file RdestOut
rf_rsrc_data  in  DATA_W  register file RsrcOut
done  out  1  one-cycle pulse when a command retires
err  out  1  one-cycle pulse when an illegal opcode retires
flags  out  4  {C, F, Z, N}, registered

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 except cmd_ready=1. Latched command, operands and flags are cleared. Reset during any state aborts the operation and issues no write.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE. There are no other transitions and no stalls.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid&cmd_ready at a posedge, latch op/rdest/rsrc/imm and go to READ.
  - cmd_* inputs are ignored in every other state.
- READ:
  - Drive rf_rdest_loc=rdest and rf_rsrc_loc=rsrc.
  - Capture rf_rdest_data and rf_rsrc_data into operand registers A and B at the end of the cycle. Register file reads are combinational.
- EXEC: compute the result and next flags from A, B and imm, and register both.
- WRITE:
  - rf_rdest_loc=rdest, rf_load=result.
  - rf_en=1 for writing ops. The write occurs at the posedge ending WRITE.
  - done=1 for every command; err=1 additionally for illegal opcodes.
  - Flags update at the same edge.
- Latency: accept edge N; write edge N+3; done high in cycle N+2..N+3. Next accept is at the earliest edge N+4. Throughput is 1 command per 4 cycles.
- rf_en is 0 outside WRITE. rf_*_loc are 0 in IDLE.
- Opcodes (result is mod 2^16):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND, 3 OR, 4 XOR: bitwise A op B
  - 5 MOV: B
  - 6 MOVI: zero-extended imm
  - 7 ADDI: A + sign-extended imm
  - 8 CMP: computes A-B; no write (rf_en=0); flags only
  - 9 LSH: A << B[3:0]
  - 10-15: illegal; no write, flags unchanged, err pulses
- Flags: updated only by ADD, SUB, ADDI and CMP; all other ops hold them.
  - Z = (result==0); N = result[15].
  - For ADD/ADDI: C = carry out of bit 15.
  - For SUB/CMP: C = 1 if A<B unsigned (borrow).
  - F = signed two's-complement overflow.
- Rdest equal to Rsrc is legal; both reads return the same register.

Optional Feature:
Macro RFSEQ_R0_ZERO_EN.
- Defined: register 0 is treated as hardwired zero. In READ, any operand sourced from index 0 is captured as 0 regardless of rf_*_data. In WRITE, rf_en is forced to 0 when rdest==0. done still pulses and flags still update normally.
- Undefined: register 0 behaves as any other register.

Test Plan:
- Reset mid-op: assert rst=0 during EXEC of ADD r1,r2 -> no rf_en pulse, cmd_ready=1, flags=0, state IDLE.
- MOVI r3,#0x7F, then MOVI r4,#0x01, then ADD r3,r4 -> rf_en writes 0x0080 to r3 exactly 3 edges after accept. done single-cycle; flags C=0,F=0,Z=0,N=0. cmd_ready low for 3 cycles after each accept.
- r5=0x7FFF, ADDI r5,#0x01 -> r5=0x8000, F=1, N=1, C=0, Z=0. Then ADDI r5,#0xFF (sign-extended -1) -> 0x7FFF, C=1, F=1.
- r6=0x0003, r7=0x0005: CMP r6,r7 -> no write, r6 still 0x0003, C=1, N=1, Z=0. CMP r6,r6 -> Z=1, C=0.
- cmd_op=12 -> err and done pulse together, rf_en never asserts, flags unchanged. cmd_valid held high continuously -> accepts exactly every 4 cycles.
- RFSEQ_R0_ZERO_EN defined: MOVI r0,#0x55 -> rf_en stays 0. MOV r8,r0 -> r8=0x0000 even if the bench's rf_rdest_data/rf_rsrc_data model returns nonzero for index 0.

Source files
------------

// File: rtl/regfile_op_sequencer.sv
// Multicycle register-file operation sequencer: IDLE -> READ -> EXEC -> WRITE.
// Optional macro RFSEQ_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_op_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rdest,
  input  logic [ADDR_W-1:0] cmd_rsrc,
  input  logic [IMM_W-1:0]  cmd_imm,
  output logic [ADDR_W-1:0] rf_rdest_loc,
  output logic [ADDR_W-1:0] rf_rsrc_loc,
  output logic              rf_en,
  output logic [DATA_W-1:0] rf_load,
  input  logic [DATA_W-1:0] rf_rdest_data,
  input  logic [DATA_W-1:0] rf_rsrc_data,
  output logic              done,
  output logic              err,
  output logic [3:0]        flags
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_MOVI = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t state, state_d;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rdest_q, rsrc_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] opa, opb;
  logic [3:0]        flags_pend;

  logic              ready_d, en_d, done_d, err_d;
  logic [ADDR_W-1:0] rdest_loc_d, rsrc_loc_d;
  logic [DATA_W-1:0] load_d;

  logic [DATA_W-1:0] alu_res, imm_sx, add_b;
  logic [DATA_W:0]   sum, diff;
  logic              alu_wr, alu_ill, alu_upd, alu_c, alu_v;
  logic [3:0]        alu_flags;
  logic              wr_ok;

  assign imm_sx = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign add_b  = (op_q == OP_ADDI) ? imm_sx : opb;
  assign sum    = {1'b0, opa} + {1'b0, add_b};
  assign diff   = {1'b0, opa} - {1'b0, opb};

`ifdef RFSEQ_R0_ZERO_EN
  assign wr_ok = (rdest_q != '0);
`else
  assign wr_ok = 1'b1;
`endif

  // ALU: result, write intent and next flags from the captured operands
  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b1;
    alu_ill   = 1'b0;
    alu_upd   = 1'b0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_flags = flags;
    case (op_q)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[MSB:0];
        alu_upd = 1'b1;
        alu_c   = sum[DATA_W];
        alu_v   = (opa[MSB] == add_b[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[MSB:0];
        alu_wr  = (op_q == OP_SUB);
        alu_upd = 1'b1;
        alu_c   = diff[DATA_W];
        alu_v   = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_MOV:  alu_res = opb;
      OP_MOVI: alu_res = DATA_W'(imm_q);
      OP_LSH:  alu_res = opa << opb[3:0];
      default: begin
        alu_wr  = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
    if (alu_upd) alu_flags = {alu_c, alu_v, (alu_res == '0), alu_res[MSB]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d     = state;
    ready_d     = 1'b0;
    rdest_loc_d = '0;
    rsrc_loc_d  = '0;
    en_d        = 1'b0;
    load_d      = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid) begin
          state_d     = READ;
          ready_d     = 1'b0;
          rdest_loc_d = cmd_rdest;
          rsrc_loc_d  = cmd_rsrc;
        end
      end
      READ: begin
        state_d     = EXEC;
        rdest_loc_d = rdest_q;
        rsrc_loc_d  = rsrc_q;
      end
      EXEC: begin
        state_d     = WRITE;
        rdest_loc_d = rdest_q;
        rsrc_loc_d  = rsrc_q;
        en_d        = alu_wr && wr_ok;
        load_d      = alu_res;
        done_d      = 1'b1;
        err_d       = alu_ill;
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready    <= 1'b1;
      rf_rdest_loc <= '0;
      rf_rsrc_loc  <= '0;
      rf_en        <= 1'b0;
      rf_load      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      flags        <= '0;
      flags_pend   <= '0;
      op_q         <= '0;
      rdest_q      <= '0;
      rsrc_q       <= '0;
      imm_q        <= '0;
      opa          <= '0;
      opb          <= '0;
    end else begin
      cmd_ready    <= ready_d;
      rf_rdest_loc <= rdest_loc_d;
      rf_rsrc_loc  <= rsrc_loc_d;
      rf_en        <= en_d;
      rf_load      <= load_d;
      done         <= done_d;
      err          <= err_d;
      if (state == IDLE && cmd_valid) begin
        op_q    <= cmd_op;
        rdest_q <= cmd_rdest;
        rsrc_q  <= cmd_rsrc;
        imm_q   <= cmd_imm;
      end
      if (state == READ) begin
`ifdef RFSEQ_R0_ZERO_EN
        opa <= (rdest_q == '0) ? '0 : rf_rdest_data;
        opb <= (rsrc_q == '0) ? '0 : rf_rsrc_data;
`else
        opa <= rf_rdest_data;
        opb <= rf_rsrc_data;
`endif
      end
      if (state == EXEC)  flags_pend <= alu_flags;
      if (state == WRITE) flags      <= flags_pend;
    end
  end

endmodule
